// File: rtl/complex_div_arb_pkg.sv
// Shared types and constants for the complex divider arbiter slice.
package complex_div_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned FP_W        = 64;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ID_W_DEF = id_width(NUM_REQ_DEF);

    typedef logic [FP_W-1:0] operand_t;

    typedef struct packed {
        operand_t im;
        operand_t re;
    } result_t;

    // Bit-for-bit copy of fpnew_pkg::status_t so divider flags pass straight through.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/complex_div_arb_id_fifo.sv
// In-order FIFO of requester IDs for operations in flight in the shared divider.
module complex_div_arb_id_fifo
    import complex_div_arb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = ID_W_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DATA_W-1:0]          head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign head_o  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + (AW+1)'(1);
                2'b01:   count_o <= count_o - (AW+1)'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/complex_div_arbiter.sv
// Round-robin sharing of one complex divider among NUM_REQ requesters.
// Optional perf counters: define COMPLEX_DIV_ARB_PERF_EN.
module complex_div_arbiter
    import complex_div_arb_pkg::*;
#(
    parameter int NUM_REQ         = NUM_REQ_DEF,
    parameter int NUM_OPERANDS    = 4,
    parameter int WIDTH           = FP_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    input  logic [NUM_REQ-1:0]                          req_valid_i,
    output logic [NUM_REQ-1:0]                          req_ready_o,
    input  logic [NUM_REQ-1:0][NUM_OPERANDS-1:0][WIDTH-1:0] req_operands_i,
    output logic [NUM_REQ-1:0]                          rsp_valid_o,
    input  logic [NUM_REQ-1:0]                          rsp_ready_i,
    output logic [2*WIDTH-1:0]                          rsp_result_o,
    output status_t                                     rsp_status_o,
    output logic                                        div_in_valid_o,
    input  logic                                        div_in_ready_i,
    output logic [NUM_OPERANDS-1:0][WIDTH-1:0]          div_operands_o,
    output logic                                        div_flush_o,
    input  logic [2*WIDTH-1:0]                          div_result_i,
    input  status_t                                     div_status_i,
    input  logic                                        div_out_valid_i,
    output logic                                        div_out_ready_o,
    output logic                                        busy_o,
    output logic                                        err_o
`ifdef COMPLEX_DIV_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][31:0]                    perf_grant_cnt_o,
    output logic [31:0]                                 perf_stall_cnt_o
`endif
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  head_id;
    logic [ID_W:0]    idx;
    logic             grant_vld;
    logic             issue;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (!grant_vld && req_valid_i[idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
        if (fifo_full || flush_i) grant_vld = 1'b0;
    end

    always_comb begin
        req_ready_o    = '0;
        div_operands_o = '0;
        if (grant_vld) begin
            req_ready_o[grant_id] = div_in_ready_i;
            div_operands_o        = req_operands_i[grant_id];
        end
    end

    assign div_in_valid_o = grant_vld;
    assign issue          = grant_vld & div_in_ready_i;
    assign div_flush_o    = flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // Orphan responses (empty FIFO or flush cycle) are accepted and discarded.
    assign drop            = fifo_empty | flush_i;
    assign div_out_ready_o = drop ? div_out_valid_i : rsp_ready_i[head_id];
    assign pop             = div_out_valid_i & div_out_ready_o & ~drop;
    assign rsp_result_o    = div_out_valid_i ? div_result_i : '0;
    assign rsp_status_o    = div_out_valid_i ? div_status_i : '0;
    assign busy_o          = (fifo_count != '0);

    always_comb begin
        rsp_valid_o = '0;
        if (!drop) rsp_valid_o[head_id] = div_out_valid_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (div_out_valid_i && fifo_empty && !flush_i) begin
            err_o <= 1'b1;
        end
    end

    complex_div_arb_id_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .DATA_W (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (issue),
        .pop_i   (pop),
        .data_i  (grant_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head_id)
    );

`ifdef COMPLEX_DIV_ARB_PERF_EN
    logic stall;
    assign stall = (|req_valid_i) & ~issue;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_grant_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (issue && grant_id == ID_W'(r) && perf_grant_cnt_o[r] != '1)
                    perf_grant_cnt_o[r] <= perf_grant_cnt_o[r] + 32'd1;
            end
            if (stall && perf_stall_cnt_o != '1)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule
